// File: rtl/multicycle_control_unit.sv
// Purpose: multicycle ARM-subset controller; sequences datapath selects/enables and holds NZCV.
// Latency: B 3, STR 4, data-processing 4, LDR 5 cycles per instruction; outputs are Moore plus decode.
// Backpressure: none; the sequence is fixed and RST aborts any instruction in flight.
module multicycle_control_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALU_Flags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALU_Code,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags_q
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    logic [3:0] state, state_nxt;
    logic [3:0] cond, rd, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       n_f, z_f, c_f, v_f;
    logic       cond_ex, legal, no_write, logic_op, rd_pc;
    logic [1:0] cmd_code;
    logic       unused_bits;

    assign cond        = Instr[19:16];
    assign op          = Instr[15:14];
    assign funct       = Instr[13:8];
    assign rd          = Instr[7:4];
    assign cmd         = funct[4:1];
    assign rd_pc       = (rd == 4'd15);
    assign unused_bits = ^Instr[3:0];
    assign {n_f, z_f, c_f, v_f} = Flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        legal    = 1'b1;
        no_write = 1'b0;
        logic_op = 1'b0;
        cmd_code = 2'b00;
        case (cmd)
            4'b0100: cmd_code = 2'b00;
            4'b0010: cmd_code = 2'b01;
            4'b0000: begin cmd_code = 2'b10; logic_op = 1'b1; end
            4'b1100: begin cmd_code = 2'b11; logic_op = 1'b1; end
            4'b1010: begin cmd_code = 2'b01; no_write = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = funct[5] ? EXECI : EXECR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: state_nxt = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            EXECR,
            EXECI:  state_nxt = ALUWB;
            default: state_nxt = FETCH;
        endcase
    end

    // Flags commit leaving EXEC; cond_ex here still reflects the pre-update NZCV.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            Flags_q <= 4'b0000;
        end else begin
            state <= state_nxt;
            if ((state == EXECR || state == EXECI) && funct[0] && cond_ex && legal) begin
                if (logic_op)
                    Flags_q[3:2] <= ALU_Flags[3:2];
                else
                    Flags_q <= ALU_Flags;
            end
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALU_Code  = 2'b00;
        ImmSrc    = 2'b00;
        RegSrc    = 2'b00;
        if (!RST) begin
            ImmSrc = op;
            RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
            case (state)
                FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                MEMADR: begin
                    ALUSrcB  = 2'b01;
                    ALU_Code = funct[3] ? 2'b00 : 2'b01;
                end
                MEMRD: AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = cond_ex;
                    PCWrite   = cond_ex & rd_pc;
                end
                MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = cond_ex;
                end
                EXECR: ALU_Code = cmd_code;
                EXECI: begin
                    ALUSrcB  = 2'b01;
                    ALU_Code = cmd_code;
                end
                ALUWB: begin
                    RegWrite = cond_ex & ~no_write & legal;
                    PCWrite  = cond_ex & ~no_write & legal & rd_pc;
                end
                BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = cond_ex;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks instruction sequences cycle by cycle
// and compares the packed control word, decode outputs and stored flags against hand values.
module tb_multicycle_control_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic [19:0] Instr;
    logic [3:0]  ALU_Flags;
    logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALU_Code, ImmSrc, RegSrc;
    logic [3:0]  Flags_q;
    int          checks = 0;
    int          failures = 0;

    multicycle_control_unit dut (
        .CLK(CLK), .RST(RST), .Instr(Instr), .ALU_Flags(ALU_Flags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALU_Code(ALU_Code), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags_q(Flags_q)
    );

    always #5 CLK = ~CLK;

    // {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALU_Code}
    logic [11:0] ctl;
    assign ctl = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALU_Code};

    function automatic logic [11:0] cw(input logic pcw, input logic irw, input logic adr,
                                       input logic mw, input logic rw, input logic [1:0] res,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] alu);
        return {pcw, irw, adr, mw, rw, res, sa, sb, alu};
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {cond, op, funct, rd, 4'h0};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] fl);
        @(negedge CLK);
        ALU_Flags = fl;
        #1;
    endtask

    logic [11:0] C_FETCH, C_DECODE, C_IDLE;

    initial begin
        C_FETCH  = cw(1, 1, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        C_DECODE = cw(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        C_IDLE   = 12'h000;
        RST = 1'b1;
        Instr = mk(4'hE, 2'b01, 6'b011001, 4'd15);
        ALU_Flags = 4'h0;

        // reset hold: everything forced low, flags cleared
        tick(4'h0);
        chk("rst_ctl", {4'h0, ctl}, {4'h0, C_IDLE});
        chk("rst_dec", {12'h0, ImmSrc, RegSrc}, 16'h0);
        chk("rst_flags", {12'h0, Flags_q}, 16'h0);
        tick(4'h0);
        RST = 1'b0;
        #1;

        // ADDS R1: cond=AL op=00 funct=001001
        Instr = mk(4'hE, 2'b00, 6'b001001, 4'd1);
        #1;
        chk("adds_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        tick(4'h0);
        chk("adds_decode", {4'h0, ctl}, {4'h0, C_DECODE});
        tick(4'b0110);
        chk("adds_execr", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00)});
        tick(4'h0);
        chk("adds_aluwb", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00)});
        chk("adds_flags", {12'h0, Flags_q}, 16'h0006);

        // CMP: funct=010101 -> SUB, no register write, sets Z
        Instr = mk(4'hE, 2'b00, 6'b010101, 4'd0);
        tick(4'h0);
        chk("cmp_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        tick(4'h0);
        tick(4'b0100);
        chk("cmp_execr", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01)});
        tick(4'h0);
        chk("cmp_aluwb", {4'h0, ctl}, {4'h0, C_IDLE});
        chk("cmp_flags", {12'h0, Flags_q}, 16'h0004);

        // BEQ taken
        Instr = mk(4'h0, 2'b10, 6'b000000, 4'd0);
        tick(4'h0);
        chk("beq_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        tick(4'h0);
        chk("beq_decode_dec", {12'h0, ImmSrc, RegSrc}, 16'b1001);
        tick(4'h0);
        chk("beq_branch", {4'h0, ctl}, {4'h0, cw(1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00)});

        // LDR PC: op=01 funct=011001 Rd=15
        Instr = mk(4'hE, 2'b01, 6'b011001, 4'd15);
        tick(4'h0);
        chk("ldr_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        tick(4'h0);
        chk("ldr_decode_dec", {12'h0, ImmSrc, RegSrc}, 16'b0100);
        tick(4'h0);
        chk("ldr_memadr", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00)});
        tick(4'h0);
        chk("ldr_memrd", {4'h0, ctl}, {4'h0, cw(0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00)});
        tick(4'h0);
        chk("ldr_memwb", {4'h0, ctl}, {4'h0, cw(1, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00)});

        // STRNE with Z=1: memory write suppressed
        Instr = mk(4'h1, 2'b01, 6'b011000, 4'd2);
        tick(4'h0);
        chk("str_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        chk("str_regsrc", {14'h0, RegSrc}, 16'b10);
        tick(4'h0);
        tick(4'h0);
        chk("str_memadr", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00)});
        tick(4'h0);
        chk("str_memwr", {4'h0, ctl}, {4'h0, cw(0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00)});

        // ADDS producing NZCV=0011
        Instr = mk(4'hE, 2'b00, 6'b001001, 4'd4);
        tick(4'h0);
        chk("str_next_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        tick(4'h0);
        tick(4'b0011);
        tick(4'h0);
        chk("adds2_flags", {12'h0, Flags_q}, 16'h0003);

        // ANDS: N,Z from ALU, C,V kept
        Instr = mk(4'hE, 2'b00, 6'b000001, 4'd3);
        tick(4'h0);
        tick(4'h0);
        tick(4'b1000);
        chk("ands_execr", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10)});
        tick(4'h0);
        chk("ands_aluwb", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00)});
        chk("ands_flags", {12'h0, Flags_q}, 16'h000B);

        // BEQ not taken (Z=0): still 3 cycles
        Instr = mk(4'h0, 2'b10, 6'b000000, 4'd0);
        tick(4'h0);
        tick(4'h0);
        tick(4'h0);
        chk("bne_branch", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00)});

        // Illegal cmd=0111 with S, immediate form
        Instr = mk(4'hE, 2'b00, 6'b101111, 4'd5);
        tick(4'h0);
        chk("bne_next_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        tick(4'h0);
        tick(4'b1111);
        chk("ill_execi", {4'h0, ctl}, {4'h0, cw(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00)});
        tick(4'h0);
        chk("ill_aluwb", {4'h0, ctl}, {4'h0, C_IDLE});
        chk("ill_flags", {12'h0, Flags_q}, 16'h000B);

        // LDR aborted by reset in MEMRD
        Instr = mk(4'hE, 2'b01, 6'b011001, 4'd1);
        tick(4'h0);
        tick(4'h0);
        tick(4'h0);
        tick(4'h0);
        chk("abort_memrd", {4'h0, ctl}, {4'h0, cw(0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00)});
        RST = 1'b1;
        #1;
        chk("abort_rst_ctl0", {4'h0, ctl}, {4'h0, C_IDLE});
        tick(4'h0);
        chk("abort_rst_ctl1", {4'h0, ctl}, {4'h0, C_IDLE});
        tick(4'h0);
        chk("abort_rst_ctl2", {4'h0, ctl}, {4'h0, C_IDLE});
        RST = 1'b0;
        #1;
        chk("abort_flags", {12'h0, Flags_q}, 16'h0);
        chk("abort_fetch", {4'h0, ctl}, {4'h0, C_FETCH});
        tick(4'h0);
        chk("abort_decode", {4'h0, ctl}, {4'h0, C_DECODE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
